// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file for the memory stage.
// It handles exception entry, ERET, MTC0/MFC0 and the Count/Compare timer.
module cp0_regfile #(
  parameter logic [31:0] STATUS_RST = 32'h0040_0000,
  parameter bit          COUNT_DIV2 = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] rdata_o,
  input  logic [5:0]  int_i,
  input  logic [31:0] exception_type_i,
  input  logic [31:0] pc_i,
  input  logic        in_delayslot_i,
  input  logic [31:0] bad_addr_i,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] badvaddr_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_int_o
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  logic [31:0] r_status, r_cause, r_epc, r_badvaddr, r_count, r_compare;
  logic        r_timer, r_tick;

  logic        w_exc, w_eret, w_mtc0, w_inc, w_match, w_addr_exc;
  logic [4:0]  w_exccode;
  logic [31:0] w_epc_next;

  // Unlisted exception codes fall into the default arm and act like "no exception".
  always_comb begin
    w_exc  = 1'b0;
    w_eret = 1'b0;
    case (exception_type_i)
      32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'ha, 32'hc: w_exc = 1'b1;
      32'he:                                           w_eret = 1'b1;
      default: ;
    endcase
  end

  assign w_addr_exc = (exception_type_i == 32'h4) || (exception_type_i == 32'h5);
  assign w_exccode  = (exception_type_i == 32'h1) ? 5'h00 : exception_type_i[4:0];
  assign w_mtc0     = we_i & ~w_exc & ~w_eret;
  assign w_inc      = COUNT_DIV2 ? r_tick : 1'b1;
  assign w_match    = (r_compare != 32'd0) && (r_count == r_compare);
  assign w_epc_next = in_delayslot_i ? (pc_i - 32'd4) : pc_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_status   <= STATUS_RST;
      r_cause    <= 32'd0;
      r_epc      <= 32'd0;
      r_badvaddr <= 32'd0;
      r_count    <= 32'd0;
      r_compare  <= 32'd0;
      r_timer    <= 1'b0;
      r_tick     <= 1'b0;
    end else begin
      r_tick <= COUNT_DIV2 ? ~r_tick : 1'b0;

      if (w_mtc0 && (waddr_i == REG_COUNT))
        r_count <= wdata_i;
      else if (w_inc)
        r_count <= r_count + 32'd1;

      // A Compare write clears the pending tick even if a match lands in the same cycle.
      if (w_mtc0 && (waddr_i == REG_COMPARE)) begin
        r_compare <= wdata_i;
        r_timer   <= 1'b0;
      end else if (w_match) begin
        r_timer <= 1'b1;
      end

      r_cause[15:10] <= {int_i[5] | r_timer, int_i[4:0]};

      if (w_exc) begin
        if (!r_status[1]) begin
          r_epc       <= w_epc_next;
          r_cause[31] <= in_delayslot_i;
        end
        r_status[1]   <= 1'b1;
        r_cause[6:2]  <= w_exccode;
        if (w_addr_exc)
          r_badvaddr <= bad_addr_i;
      end else if (w_eret) begin
        r_status[1] <= 1'b0;
      end else if (w_mtc0) begin
        case (waddr_i)
          REG_STATUS: begin
            r_status[15:8] <= wdata_i[15:8];
            r_status[1:0]  <= wdata_i[1:0];
          end
          REG_CAUSE: r_cause[9:8] <= wdata_i[9:8];
          REG_EPC:   r_epc        <= wdata_i;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rdata_o = 32'd0;
    case (raddr_i)
      REG_BADVADDR: rdata_o = r_badvaddr;
      REG_COUNT:    rdata_o = r_count;
      REG_COMPARE:  rdata_o = r_compare;
      REG_STATUS:   rdata_o = r_status;
      REG_CAUSE:    rdata_o = r_cause;
      REG_EPC:      rdata_o = r_epc;
      default:      rdata_o = 32'd0;
    endcase
  end

  assign status_o    = r_status;
  assign cause_o     = r_cause;
  assign epc_o       = r_epc;
  assign badvaddr_o  = r_badvaddr;
  assign count_o     = r_count;
  assign compare_o   = r_compare;
  assign timer_int_o = r_timer;

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed bench for cp0_regfile: reset, timer, exception entry/ERET, MTC0 masking, MFC0.
module tb_cp0_regfile;
  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [4:0]  raddr_i;
  logic [31:0] rdata_o;
  logic [5:0]  int_i;
  logic [31:0] exception_type_i;
  logic [31:0] pc_i;
  logic        in_delayslot_i;
  logic [31:0] bad_addr_i;
  logic [31:0] status_o, cause_o, epc_o, badvaddr_o, count_o, compare_o;
  logic        timer_int_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cp0_regfile #(.STATUS_RST(32'h0040_0000), .COUNT_DIV2(1'b1)) dut (
    .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .raddr_i(raddr_i), .rdata_o(rdata_o), .int_i(int_i),
    .exception_type_i(exception_type_i), .pc_i(pc_i), .in_delayslot_i(in_delayslot_i),
    .bad_addr_i(bad_addr_i), .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
    .badvaddr_o(badvaddr_o), .count_o(count_o), .compare_o(compare_o),
    .timer_int_o(timer_int_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    repeat (10) step();
    checks++; if (count_o !== 32'd5) begin failures++; $display("FAIL reset_count: got %h expected %h", count_o, 32'd5); end
    checks++; if (status_o !== 32'h0040_0000) begin failures++; $display("FAIL reset_status: got %h expected %h", status_o, 32'h0040_0000); end
    checks++; if (cause_o !== 32'd0) begin failures++; $display("FAIL reset_cause: got %h expected 0", cause_o); end
    checks++; if (epc_o !== 32'd0) begin failures++; $display("FAIL reset_epc: got %h expected 0", epc_o); end
    checks++; if (badvaddr_o !== 32'd0) begin failures++; $display("FAIL reset_badvaddr: got %h expected 0", badvaddr_o); end
    checks++; if (compare_o !== 32'd0) begin failures++; $display("FAIL reset_compare: got %h expected 0", compare_o); end
    checks++; if (timer_int_o !== 1'b0) begin failures++; $display("FAIL reset_timer: got %b expected 0", timer_int_o); end
    raddr_i = 5'd12; #1;
    checks++; if (rdata_o !== 32'h0040_0000) begin failures++; $display("FAIL reset_mfc0_status: got %h expected %h", rdata_o, 32'h0040_0000); end
  endtask

  task automatic test_timer();
    bit found = 1'b0;
    we_i = 1'b1; waddr_i = 5'd11; wdata_i = 32'd8;
    step();
    we_i = 1'b0;
    checks++; if (compare_o !== 32'd8) begin failures++; $display("FAIL timer_compare_write: got %h expected %h", compare_o, 32'd8); end
    for (int i = 0; i < 40; i++) begin
      if (count_o == 32'd8) begin found = 1'b1; break; end
      step();
    end
    checks++; if (!found) begin failures++; $display("FAIL timer_wait_count8: got %h expected %h", count_o, 32'd8); return; end
    checks++; if (timer_int_o !== 1'b0) begin failures++; $display("FAIL timer_before_match: got %b expected 0", timer_int_o); end
    step();
    checks++; if (timer_int_o !== 1'b1) begin failures++; $display("FAIL timer_set: got %b expected 1", timer_int_o); end
    checks++; if (cause_o[15] !== 1'b0) begin failures++; $display("FAIL timer_cause15_lag: got %b expected 0", cause_o[15]); end
    // Compare still matches Count on this edge; the write must win.
    we_i = 1'b1; waddr_i = 5'd11; wdata_i = 32'h20;
    step();
    we_i = 1'b0;
    checks++; if (timer_int_o !== 1'b0) begin failures++; $display("FAIL timer_clear_wins: got %b expected 0", timer_int_o); end
    checks++; if (cause_o[15] !== 1'b1) begin failures++; $display("FAIL timer_cause15: got %b expected 1", cause_o[15]); end
    checks++; if (count_o !== 32'd9) begin failures++; $display("FAIL timer_count9: got %h expected %h", count_o, 32'd9); end
    step();
    checks++; if (cause_o[15] !== 1'b0) begin failures++; $display("FAIL timer_cause15_clear: got %b expected 0", cause_o[15]); end
    we_i = 1'b1; waddr_i = 5'd9; wdata_i = 32'hFFFF_FFFF;
    step();
    we_i = 1'b0;
    checks++; if (count_o !== 32'hFFFF_FFFF) begin failures++; $display("FAIL count_write_override: got %h expected %h", count_o, 32'hFFFF_FFFF); end
    step();
    checks++; if (count_o !== 32'hFFFF_FFFF) begin failures++; $display("FAIL count_hold_half: got %h expected %h", count_o, 32'hFFFF_FFFF); end
    step();
    checks++; if (count_o !== 32'd0) begin failures++; $display("FAIL count_wrap: got %h expected 0", count_o); end
  endtask

  task automatic test_exc_entry();
    exception_type_i = 32'h4; pc_i = 32'hBFC0_0100; in_delayslot_i = 1'b0; bad_addr_i = 32'h3;
    step();
    exception_type_i = 32'h0;
    checks++; if (epc_o !== 32'hBFC0_0100) begin failures++; $display("FAIL exc4_epc: got %h expected %h", epc_o, 32'hBFC0_0100); end
    checks++; if (badvaddr_o !== 32'h3) begin failures++; $display("FAIL exc4_badvaddr: got %h expected %h", badvaddr_o, 32'h3); end
    checks++; if (cause_o[6:2] !== 5'h04) begin failures++; $display("FAIL exc4_exccode: got %h expected %h", cause_o[6:2], 5'h04); end
    checks++; if (cause_o[31] !== 1'b0) begin failures++; $display("FAIL exc4_bd: got %b expected 0", cause_o[31]); end
    checks++; if (status_o !== 32'h0040_0002) begin failures++; $display("FAIL exc4_status: got %h expected %h", status_o, 32'h0040_0002); end
  endtask

  task automatic test_nested_exc();
    exception_type_i = 32'he;
    step();
    checks++; if (status_o[1] !== 1'b0) begin failures++; $display("FAIL eret_exl: got %b expected 0", status_o[1]); end
    exception_type_i = 32'h8; pc_i = 32'h8000_0010; in_delayslot_i = 1'b1;
    step();
    checks++; if (epc_o !== 32'h8000_000C) begin failures++; $display("FAIL exc8_ds_epc: got %h expected %h", epc_o, 32'h8000_000C); end
    checks++; if (cause_o[31] !== 1'b1) begin failures++; $display("FAIL exc8_bd: got %b expected 1", cause_o[31]); end
    checks++; if (cause_o[6:2] !== 5'h08) begin failures++; $display("FAIL exc8_exccode: got %h expected %h", cause_o[6:2], 5'h08); end
    exception_type_i = 32'hc; pc_i = 32'h8000_0100; in_delayslot_i = 1'b0;
    step();
    exception_type_i = 32'h0;
    checks++; if (epc_o !== 32'h8000_000C) begin failures++; $display("FAIL excc_epc_hold: got %h expected %h", epc_o, 32'h8000_000C); end
    checks++; if (cause_o[6:2] !== 5'h0C) begin failures++; $display("FAIL excc_exccode: got %h expected %h", cause_o[6:2], 5'h0C); end
    checks++; if (cause_o[31] !== 1'b1) begin failures++; $display("FAIL excc_bd_hold: got %b expected 1", cause_o[31]); end
    checks++; if (badvaddr_o !== 32'h3) begin failures++; $display("FAIL excc_badvaddr_hold: got %h expected %h", badvaddr_o, 32'h3); end
  endtask

  task automatic test_priority();
    exception_type_i = 32'he;
    step();
    checks++; if (status_o !== 32'h0040_0000) begin failures++; $display("FAIL eret_status: got %h expected %h", status_o, 32'h0040_0000); end
    we_i = 1'b1; waddr_i = 5'd12; wdata_i = 32'hFFFF_FFFF;
    exception_type_i = 32'h8; pc_i = 32'h1234_0000; in_delayslot_i = 1'b0;
    step();
    checks++; if (status_o !== 32'h0040_0002) begin failures++; $display("FAIL exc_over_mtc0_status: got %h expected %h", status_o, 32'h0040_0002); end
    checks++; if (epc_o !== 32'h1234_0000) begin failures++; $display("FAIL exc_over_mtc0_epc: got %h expected %h", epc_o, 32'h1234_0000); end
    checks++; if (cause_o[31] !== 1'b0) begin failures++; $display("FAIL exc_over_mtc0_bd: got %b expected 0", cause_o[31]); end
    exception_type_i = 32'he;
    step();
    checks++; if (status_o !== 32'h0040_0000) begin failures++; $display("FAIL eret_over_mtc0: got %h expected %h", status_o, 32'h0040_0000); end
    exception_type_i = 32'h0;
    step();
    we_i = 1'b0;
    checks++; if (status_o !== 32'h0040_FF03) begin failures++; $display("FAIL mtc0_status_mask: got %h expected %h", status_o, 32'h0040_FF03); end
  endtask

  task automatic test_cause_mfc0();
    int_i = 6'b000001;
    step();
    checks++; if (cause_o[15:10] !== 6'b000001) begin failures++; $display("FAIL cause_hw0: got %b expected %b", cause_o[15:10], 6'b000001); end
    checks++; if (cause_o !== 32'h0000_0420) begin failures++; $display("FAIL cause_value: got %h expected %h", cause_o, 32'h0000_0420); end
    we_i = 1'b1; waddr_i = 5'd13; wdata_i = 32'hFFFF_FFFF;
    step();
    we_i = 1'b0;
    checks++; if (cause_o !== 32'h0000_0720) begin failures++; $display("FAIL mtc0_cause_mask: got %h expected %h", cause_o, 32'h0000_0720); end
    raddr_i = 5'd7; #1;
    checks++; if (rdata_o !== 32'd0) begin failures++; $display("FAIL mfc0_reg7: got %h expected 0", rdata_o); end
    raddr_i = 5'd13; #1;
    checks++; if (rdata_o !== 32'h0000_0720) begin failures++; $display("FAIL mfc0_cause: got %h expected %h", rdata_o, 32'h0000_0720); end
    raddr_i = 5'd14; #1;
    checks++; if (rdata_o !== 32'h1234_0000) begin failures++; $display("FAIL mfc0_epc: got %h expected %h", rdata_o, 32'h1234_0000); end
    we_i = 1'b1; waddr_i = 5'd8; wdata_i = 32'h0000_DEAD;
    step();
    checks++; if (badvaddr_o !== 32'h3) begin failures++; $display("FAIL mtc0_badvaddr_ignored: got %h expected %h", badvaddr_o, 32'h3); end
    waddr_i = 5'd14; wdata_i = 32'hCAFE_0000; exception_type_i = 32'h3;
    step();
    we_i = 1'b0; exception_type_i = 32'h0;
    checks++; if (epc_o !== 32'hCAFE_0000) begin failures++; $display("FAIL unknown_code_mtc0_epc: got %h expected %h", epc_o, 32'hCAFE_0000); end
    checks++; if (status_o !== 32'h0040_FF03) begin failures++; $display("FAIL unknown_code_status: got %h expected %h", status_o, 32'h0040_FF03); end
  endtask

  task automatic test_mid_reset();
    rst = 1'b1; we_i = 1'b1; waddr_i = 5'd12; wdata_i = 32'hFFFF_FFFF;
    exception_type_i = 32'h4; bad_addr_i = 32'h55; int_i = 6'b100001;
    step();
    checks++; if (status_o !== 32'h0040_0000) begin failures++; $display("FAIL midrst_status: got %h expected %h", status_o, 32'h0040_0000); end
    checks++; if (cause_o !== 32'd0) begin failures++; $display("FAIL midrst_cause: got %h expected 0", cause_o); end
    checks++; if (epc_o !== 32'd0) begin failures++; $display("FAIL midrst_epc: got %h expected 0", epc_o); end
    checks++; if (badvaddr_o !== 32'd0) begin failures++; $display("FAIL midrst_badvaddr: got %h expected 0", badvaddr_o); end
    checks++; if (count_o !== 32'd0) begin failures++; $display("FAIL midrst_count: got %h expected 0", count_o); end
    checks++; if (compare_o !== 32'd0) begin failures++; $display("FAIL midrst_compare: got %h expected 0", compare_o); end
    rst = 1'b0; we_i = 1'b0; exception_type_i = 32'h0; int_i = 6'd0;
  endtask

  initial begin
    rst = 1'b1; we_i = 1'b0; waddr_i = 5'd0; wdata_i = 32'd0; raddr_i = 5'd0;
    int_i = 6'd0; exception_type_i = 32'd0; pc_i = 32'd0; in_delayslot_i = 1'b0;
    bad_addr_i = 32'd0;
    test_reset();
    test_timer();
    test_exc_entry();
    test_nested_exc();
    test_priority();
    test_cause_mfc0();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
